// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the 256x8 RAM arbiter.
package ram_arb_pkg;
   localparam logic [7:0] WINDOW_HI = 8'h80;
   localparam int RAM_DEPTH = 256;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef logic port_id_t;
endpackage

// File: rtl/ram_rr_picker.sv
// ram_rr_picker: two-port grant select; RAM_ARB_ROUND_ROBIN_EN alternates ties, else port 0 wins.
module ram_rr_picker
   import ram_arb_pkg::*;
(
   input  logic [1:0] valid,
`ifdef RAM_ARB_ROUND_ROBIN_EN
   input  port_id_t   last,
`endif
   output port_id_t   grant
);
`ifdef RAM_ARB_ROUND_ROBIN_EN
   assign grant = &valid ? !last : valid[1];
`else
   assign grant = valid[1] && !valid[0];
`endif
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter/sequencer for the 0x8000-0x80FF RAM window.
// RAM_ARB_ROUND_ROBIN_EN enables round-robin tie-breaking (default: port 0 priority).
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int RAM_AW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic              req0_we,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic              req1_we,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              resp0_valid,
   output logic [DATA_W-1:0] resp0_rdata,
   output logic              resp0_err,
   output logic              resp1_valid,
   output logic [DATA_W-1:0] resp1_rdata,
   output logic              resp1_err,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata
);
   state_t state, state_n;
   port_id_t grant, id_q;
   logic any, accept, we_q, err_q, ram_we_q, resp_e, rd_ok, we_w, err_w;
   logic [1:0] resp_v;
   logic [ADDR_W-1:0] addr_w;
`ifdef RAM_ARB_ROUND_ROBIN_EN
   port_id_t last;
   always_ff @(posedge clk)
      if (rst) last <= 1'b1;
      else if (accept) last <= grant;
`endif
   ram_rr_picker u_pick (
      .valid({req1_valid, req0_valid}),
`ifdef RAM_ARB_ROUND_ROBIN_EN
      .last(last),
`endif
      .grant(grant)
   );
   assign any        = req0_valid || req1_valid;
   assign accept     = state == IDLE && any && !rst;
   assign req0_ready = accept && !grant;
   assign req1_ready = accept && grant;
   assign addr_w     = grant ? req1_addr : req0_addr;
   assign we_w       = grant ? req1_we : req0_we;
   assign err_w      = addr_w[ADDR_W-1:RAM_AW] != WINDOW_HI;
   always_comb
      state_n = state == IDLE ? (any ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
   always_ff @(posedge clk)
      if (rst) begin
         state     <= IDLE;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we_q  <= 1'b0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         id_q      <= 1'b0;
         resp_v    <= 2'b00;
         resp_e    <= 1'b0;
      end else begin
         state    <= state_n;
         ram_we_q <= accept && we_w && !err_w;
         resp_v   <= state == ACCESS ? (id_q ? 2'b10 : 2'b01) : 2'b00;
         resp_e   <= state == ACCESS && err_q;
         if (accept) begin
            ram_addr  <= addr_w[RAM_AW-1:0];
            ram_wdata <= grant ? req1_wdata : req0_wdata;
            we_q      <= we_w;
            err_q     <= err_w;
            id_q      <= grant;
         end
      end
   // Reset in the same cycle kills the RAM write and any response in flight.
   assign ram_we      = ram_we_q && !rst;
   assign rd_ok       = !we_q && !err_q;
   assign resp0_valid = resp_v[0] && !rst;
   assign resp1_valid = resp_v[1] && !rst;
   assign resp0_err   = resp0_valid && resp_e;
   assign resp1_err   = resp1_valid && resp_e;
   assign resp0_rdata = resp0_valid && rd_ok ? ram_rdata : '0;
   assign resp1_rdata = resp1_valid && rd_ok ? ram_rdata : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed tests plus a per-cycle transaction-level model of the arbiter.
module tb_ram_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic req0_valid = 1'b0, req1_valid = 1'b0, req0_we = 1'b0, req1_we = 1'b0;
   logic [15:0] req0_addr = '0, req1_addr = '0;
   logic [7:0] req0_wdata = '0, req1_wdata = '0;
   logic req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err, ram_we;
   logic [7:0] resp0_rdata, resp1_rdata, ram_addr, ram_wdata;
   logic [7:0] ram_rdata = '0;
   logic [7:0] mem [256] = '{default: 8'h00};
   logic [7:0] refmem [256] = '{default: 8'h00};
   int n_tests = 0, n_fail = 0, cyc = 0, we_cnt = 0, s0_cnt = 0, s1_cnt = 0;

   ram_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
      .req0_we(req0_we), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
      .req1_we(req1_we), .req1_wdata(req1_wdata),
      .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
      .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Behavioural ram_block: registered read, write when enabled.
   always @(posedge clk)
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model: phase of the one transaction in flight, plus a reference memory.
   int ph = 0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
   bit m_last = 1'b1;
`endif
   bit m_p, m_we, m_err;
   logic [15:0] m_a;
   logic [7:0] m_d, m_rd;

   always @(negedge clk) begin
      bit win, e_r0, e_r1, e_we, e_s0, e_s1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      win = (req0_valid && req1_valid) ? !m_last : req1_valid;
`else
      win = !req0_valid;
`endif
      e_r0 = !rst && ph == 0 && (req0_valid || req1_valid) && !win;
      e_r1 = !rst && ph == 0 && (req0_valid || req1_valid) && win;
      e_we = !rst && ph == 1 && m_we && !m_err;
      e_s0 = !rst && ph == 2 && !m_p;
      e_s1 = !rst && ph == 2 && m_p;
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("ram_we", ram_we, e_we);
      if (!rst && ph == 1) begin
         chk("ram_addr", ram_addr, m_a[7:0]);
         chk("ram_wdata", ram_wdata, m_d);
      end
      chk("resp0_valid", resp0_valid, e_s0);
      chk("resp1_valid", resp1_valid, e_s1);
      chk("resp0_err", resp0_err, e_s0 && m_err);
      chk("resp1_err", resp1_err, e_s1 && m_err);
      chk("resp0_rdata", resp0_rdata, e_s0 ? m_rd : 8'h00);
      chk("resp1_rdata", resp1_rdata, e_s1 ? m_rd : 8'h00);
      if (ram_we) we_cnt++;
      if (resp0_valid) s0_cnt++;
      if (resp1_valid) s1_cnt++;
      if (rst) begin
         ph = 0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         m_last = 1'b1;
`endif
      end else if (ph == 0) begin
         if (req0_valid || req1_valid) begin
            m_p   = win;
            m_a   = win ? req1_addr : req0_addr;
            m_we  = win ? req1_we : req0_we;
            m_d   = win ? req1_wdata : req0_wdata;
            m_err = m_a[15:8] != 8'h80;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            m_last = win;
`endif
            ph = 1;
         end
      end else if (ph == 1) begin
         m_rd = (m_we || m_err) ? 8'h00 : refmem[m_a[7:0]];
         if (m_we && !m_err) refmem[m_a[7:0]] = m_d;
         ph = 2;
      end else ph = 0;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One transaction on port p; wa = cycles waited for ready, lat = cycles from accept to response.
   task automatic txn(input bit p, input logic [15:0] a, input logic w, input logic [7:0] d,
                      output logic [7:0] rd, output logic e, output int lat, output int wa);
      bit got;
      rd = '0; e = 1'b0; lat = -1; wa = -1; got = 1'b0;
      if (!p) begin req0_valid = 1; req0_addr = a; req0_we = w; req0_wdata = d; end
      else begin req1_valid = 1; req1_addr = a; req1_we = w; req1_wdata = d; end
      for (int n = 1; n <= 20 && !got; n++) begin
         @(negedge clk);
         if (p ? req1_ready : req0_ready) begin got = 1'b1; wa = n; end
      end
      chk("accept_seen", got, 1);
      @(posedge clk);
      #1 req0_valid = 0; req1_valid = 0;
      got = 1'b0;
      for (int n = 1; n <= 10 && !got; n++) begin
         @(negedge clk);
         if (p ? resp1_valid : resp0_valid) begin
            got = 1'b1; lat = n;
            rd = p ? resp1_rdata : resp0_rdata;
            e = p ? resp1_err : resp0_err;
         end
      end
      chk("resp_seen", got, 1);
      idle(1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] rd;
      logic e;
      int lat, wa, wc, sc;
      int g[$], acc[$];
      int exp_g[6];
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_ram_addr", ram_addr, 8'h00);
      chk("rst_ram_wdata", ram_wdata, 8'h00);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_resp0", resp0_valid, 0);
      idle(1);
      wc = we_cnt;
      txn(0, 16'h8012, 1, 8'hA5, rd, e, lat, wa);
      chk("wr8012_err", e, 0);
      chk("wr8012_rdata", rd, 8'h00);
      chk("wr8012_lat", lat, 2);
      chk("wr8012_we_cycles", we_cnt - wc, 1);
      wc = we_cnt;
      txn(0, 16'h8012, 0, 8'h00, rd, e, lat, wa);
      chk("rd8012_rdata", rd, 8'hA5);
      chk("rd8012_err", e, 0);
      chk("rd8012_lat", lat, 2);
      chk("rd8012_we_cycles", we_cnt - wc, 0);
      txn(0, 16'h8034, 0, 8'h00, rd, e, lat, wa);
      chk("rd8034_rdata", rd, 8'h00);
      wc = we_cnt; sc = s0_cnt;
      txn(1, 16'h9034, 0, 8'h00, rd, e, lat, wa);
      chk("rd9034_err", e, 1);
      chk("rd9034_rdata", rd, 8'h00);
      txn(1, 16'h9034, 1, 8'hFF, rd, e, lat, wa);
      chk("wr9034_err", e, 1);
      chk("wr9034_lat", lat, 2);
      chk("oow_we_cycles", we_cnt - wc, 0);
      chk("oow_no_port0_resp", s0_cnt - sc, 0);
      // Both ports contend continuously.
      req0_valid = 1; req0_addr = 16'h8000; req0_we = 0;
      req1_valid = 1; req1_addr = 16'h80FF; req1_we = 0;
      for (int n = 0; n < 40 && g.size() < 6; n++) begin
         @(negedge clk);
         if (req0_ready) g.push_back(0);
         else if (req1_ready) g.push_back(1);
      end
      @(posedge clk);
      #1 req0_valid = 0; req1_valid = 0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      exp_g = '{0, 1, 0, 1, 0, 1};
`else
      exp_g = '{0, 0, 0, 0, 0, 0};
`endif
      chk("grant_count", g.size(), 6);
      foreach (g[i]) chk($sformatf("grant_%0d", i), g[i], exp_g[i]);
      idle(3);
      // Port 0 holds valid: accepts every third cycle.
      req0_valid = 1; req0_addr = 16'h8012; req0_we = 0;
      for (int n = 0; n < 40 && acc.size() < 3; n++) begin
         @(negedge clk);
         if (req0_ready) acc.push_back(cyc);
      end
      @(posedge clk);
      #1 req0_valid = 0;
      chk("b2b_count", acc.size(), 3);
      if (acc.size() == 3) begin
         chk("b2b_gap1", acc[1] - acc[0], 3);
         chk("b2b_gap2", acc[2] - acc[1], 3);
      end
      idle(3);
      // Reset during the ACCESS cycle of a write.
      txn(0, 16'h8001, 1, 8'h5A, rd, e, lat, wa);
      wc = we_cnt; sc = s0_cnt + s1_cnt;
      req0_valid = 1; req0_addr = 16'h8001; req0_we = 1; req0_wdata = 8'h3C;
      @(negedge clk);
      chk("rst_t_accept", req0_ready, 1);
      @(posedge clk);
      #1 req0_valid = 0; rst = 1;
      @(negedge clk);
      chk("rst_t_ram_we", ram_we, 0);
      @(posedge clk);
      #1 rst = 0;
      txn(0, 16'h8001, 0, 8'h00, rd, e, lat, wa);
      chk("rst_t_idle_after", wa, 1);
      chk("rst_t_old_value", rd, 8'h5A);
      chk("rst_t_no_write", we_cnt - wc, 0);
      chk("rst_t_resp_count", s0_cnt + s1_cnt - sc, 1);
      // Index boundaries.
      txn(0, 16'h80FF, 1, 8'h11, rd, e, lat, wa);
      txn(1, 16'h8000, 1, 8'h22, rd, e, lat, wa);
      txn(0, 16'h80FF, 0, 8'h00, rd, e, lat, wa);
      chk("rd80FF", rd, 8'h11);
      txn(1, 16'h8000, 0, 8'h00, rd, e, lat, wa);
      chk("rd8000", rd, 8'h22);
      chk("rd8000_lat", lat, 2);
      idle(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
